// File: rtl/draw_seq_pkg.sv
// Shared state type and widths for the draw source sequencer.
package draw_seq_pkg;

    localparam int MAX_SOURCES = 16;
    localparam int COUNT_W     = 8;
    localparam int WDOG_W      = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/draw_seq_next_finder.sv
// Priority encoder: lowest enabled source index strictly above cur, or from 0 when from_start.
module draw_seq_next_finder
    import draw_seq_pkg::*;
#(
    parameter int NUM_SOURCES = 3,
    parameter int SEL_W       = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] mask,
    input  logic [SEL_W-1:0]       cur,
    input  logic                   from_start,
    output logic [SEL_W-1:0]       next_idx,
    output logic                   found
);

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (!found && mask[i] && (from_start || (i > 32'(cur)))) begin
                found    = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/draw_source_sequencer.sv
// Per-frame write-port scheduler: grants enabled draw sources in index order, swaps on full frames.
// Optional per-source watchdog with abort: define DRAW_SEQ_TIMEOUT_EN.
module draw_source_sequencer
    import draw_seq_pkg::*;
#(
    parameter int NUM_SOURCES    = 3,
    parameter int SEL_W          = $clog2(NUM_SOURCES),
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame,
    input  logic [NUM_SOURCES-1:0] enable_mask,
    input  logic [NUM_SOURCES-1:0] src_done,
    output logic [NUM_SOURCES-1:0] src_start,
    output logic [NUM_SOURCES-1:0] src_abort,
    output logic [SEL_W-1:0]       write_source_sel,
    output logic                   buffer_swap,
    output logic                   drawing,
    output logic [COUNT_W-1:0]     overrun_count,
    output logic [COUNT_W-1:0]     timeout_count
);

    if (NUM_SOURCES < 2 || NUM_SOURCES > MAX_SOURCES) begin : g_bad_num_sources
        $error("draw_source_sequencer: NUM_SOURCES must be 2..16");
    end

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       cur_q, cur_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    logic                   swap_q, swap_d;
    logic [COUNT_W-1:0]     overrun_q, overrun_d;

    logic [SEL_W-1:0]       first_idx, next_idx;
    logic                   first_found, next_found;
    logic                   cur_done, expire, advance;
    logic                   service, late;

    draw_seq_next_finder #(.NUM_SOURCES(NUM_SOURCES), .SEL_W(SEL_W)) u_first (
        .mask       (enable_mask),
        .cur        ('0),
        .from_start (1'b1),
        .next_idx   (first_idx),
        .found      (first_found)
    );

    draw_seq_next_finder #(.NUM_SOURCES(NUM_SOURCES), .SEL_W(SEL_W)) u_next (
        .mask       (mask_q),
        .cur        (cur_q),
        .from_start (1'b0),
        .next_idx   (next_idx),
        .found      (next_found)
    );

    assign cur_done = src_done[cur_q];
    assign advance  = (state_q == RUN) && (cur_done || expire);

    // A frame is serviced when nothing is drawing, including the cycle the last source finishes.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        mask_d    = mask_q;
        swap_d    = 1'b0;
        overrun_d = overrun_q;
        service   = 1'b0;
        late      = 1'b0;
        case (state_q)
            IDLE:    service = frame;
            LAUNCH: begin
                state_d = RUN;
                late    = frame;
            end
            RUN: begin
                if (advance && next_found) begin
                    state_d = LAUNCH;
                    cur_d   = next_idx;
                    late    = frame;
                end else if (advance) begin
                    state_d = DONE;
                    service = frame;
                end else begin
                    late = frame;
                end
            end
            DONE:    service = frame;
            default: state_d = IDLE;
        endcase
        if (service) begin
            mask_d  = enable_mask;
            cur_d   = first_idx;
            state_d = first_found ? LAUNCH : DONE;
            swap_d  = (state_q != IDLE);
        end
        if (late && (overrun_q != '1)) begin
            overrun_d = overrun_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            mask_q    <= '0;
            swap_q    <= 1'b0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            mask_q    <= mask_d;
            swap_q    <= swap_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        src_start = '0;
        if (state_q == LAUNCH) begin
            src_start[cur_q] = 1'b1;
        end
    end

    assign drawing          = (state_q == LAUNCH) || (state_q == RUN);
    assign write_source_sel = drawing ? cur_q : '0;
    assign buffer_swap      = swap_q;
    assign overrun_count    = overrun_q;

`ifdef DRAW_SEQ_TIMEOUT_EN
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [COUNT_W-1:0] tmo_q, tmo_d;

    // Done in the expiry cycle takes priority, so no abort is raised.
    assign expire = (state_q == RUN) && !cur_done && (wdog_q == WDOG_W'(TIMEOUT_CYCLES));

    always_comb begin
        wdog_d = wdog_q;
        tmo_d  = tmo_q;
        if (state_q == LAUNCH) begin
            wdog_d = '0;
        end else if (state_q == RUN) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (expire && (tmo_q != '1)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wdog_q <= '0;
            tmo_q  <= '0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end

    always_comb begin
        src_abort = '0;
        if (expire) begin
            src_abort[cur_q] = 1'b1;
        end
    end

    assign timeout_count = tmo_q;
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign src_abort      = '0;
    assign timeout_count  = '0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0) ^ (WDOG_W > 0);
`endif

endmodule

// File: tb/tb_draw_source_sequencer.sv
// Randomized and directed bench for draw_source_sequencer against a set-of-remaining-sources model.
`timescale 1ns/1ps
module tb_draw_source_sequencer;

    localparam int NS  = 3;
    localparam int SW  = 2;
    localparam int TMO = 50;
`ifdef DRAW_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          frame = 1'b0;
    logic [NS-1:0] enable_mask = '0;
    logic [NS-1:0] src_done = '0;
    logic [NS-1:0] src_start, src_abort;
    logic [SW-1:0] write_source_sel;
    logic          buffer_swap, drawing;
    logic [7:0]    overrun_count, timeout_count;

    draw_source_sequencer #(
        .NUM_SOURCES    (NS),
        .SEL_W          (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .frame            (frame),
        .enable_mask      (enable_mask),
        .src_done         (src_done),
        .src_start        (src_start),
        .src_abort        (src_abort),
        .write_source_sel (write_source_sel),
        .buffer_swap      (buffer_swap),
        .drawing          (drawing),
        .overrun_count    (overrun_count),
        .timeout_count    (timeout_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_pass = 0;
    int n_tot = 0;
    int due[NS];
    int dly[NS];
    int start_cyc[NS];
    int abort_cyc[NS];
    int swap_cyc;
    bit noise_en = 1'b0;
    bit rand_mask = 1'b0;

    // Model: the set of sources still to draw this frame; the current one is its lowest member.
    logic [NS-1:0] m_rem = '0;
    bit            m_launch = 1'b0;
    bit            m_swap = 1'b0;
    bit            m_seen = 1'b0;
    int            m_ovr = 0;
    int            m_tmo = 0;
    int            m_age = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lowest(input logic [NS-1:0] r);
        for (int i = 0; i < NS; i++) if (r[i]) return i;
        return 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(posedge clk or negedge resetN) begin : model
        logic [NS-1:0] rem;
        bit busy, fin, nl, timed;
        int cur, ovr, tmo, age;
        if (!resetN) begin
            m_rem <= '0; m_launch <= 1'b0; m_swap <= 1'b0; m_seen <= 1'b0;
            m_ovr <= 0; m_tmo <= 0; m_age <= 0;
        end else begin
            rem = m_rem; ovr = m_ovr; tmo = m_tmo; age = m_age;
            busy = (rem != '0); fin = 1'b0; nl = 1'b0;
            if (busy) begin
                if (m_launch) age = 0;
                else begin
                    cur = lowest(rem);
                    timed = TMO_EN && !src_done[cur] && (age == TMO);
                    if (src_done[cur] || timed) begin
                        if (timed && tmo < 255) tmo++;
                        rem[cur] = 1'b0;
                        if (rem != '0) nl = 1'b1; else fin = 1'b1;
                    end else age++;
                end
            end
            m_swap <= 1'b0;
            if (frame) begin
                if (!busy || fin) begin
                    m_swap <= m_seen;
                    m_seen <= 1'b1;
                    rem = enable_mask;
                    nl = (rem != '0);
                end else if (ovr < 255) ovr++;
            end
            m_rem <= rem; m_launch <= nl; m_ovr <= ovr; m_tmo <= tmo; m_age <= age;
        end
    end

    always @(negedge clk) begin : cmp
        logic [NS-1:0] e_start, e_abort;
        bit busy;
        int cur;
        busy = (m_rem != '0);
        cur = lowest(m_rem);
        e_start = '0;
        e_abort = '0;
        if (busy && m_launch) e_start[cur] = 1'b1;
        if (busy && !m_launch && TMO_EN && !src_done[cur] && m_age == TMO) e_abort[cur] = 1'b1;
        check("src_start", int'(src_start), int'(e_start));
        check("src_abort", int'(src_abort), int'(e_abort));
        check("write_source_sel", int'(write_source_sel), busy ? cur : 0);
        check("drawing", int'(drawing), int'(busy));
        check("buffer_swap", int'(buffer_swap), int'(m_swap));
        check("overrun_count", int'(overrun_count), m_ovr);
        check("timeout_count", int'(timeout_count), m_tmo);
        for (int i = 0; i < NS; i++) begin
            if (src_start[i]) begin start_cyc[i] = cyc; due[i] = cyc + dly[i]; end
            if (src_abort[i]) abort_cyc[i] = cyc;
        end
        if (buffer_swap) swap_cyc = cyc;
    end

    task automatic step(input bit f);
        @(posedge clk);
        #1;
        frame = f;
        for (int i = 0; i < NS; i++) src_done[i] = (due[i] == cyc);
        if (noise_en && $urandom_range(0, 5) == 0) src_done[$urandom_range(0, NS-1)] = 1'b1;
        if (rand_mask) enable_mask = NS'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic clear_log();
        for (int i = 0; i < NS; i++) begin start_cyc[i] = -1; abort_cyc[i] = -1; due[i] = -1; end
        swap_cyc = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int f, f2;
        clear_log();
        dly = '{5, 5, 5};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_drawing", int'(drawing), 0);
        check("reset_start", int'(src_start), 0);
        check("reset_swap", int'(buffer_swap), 0);
        check("reset_overrun", int'(overrun_count), 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        idle(3);

        // Three sources, 5-cycle draws; first frame never swaps
        enable_mask = 3'b111;
        step(1'b1); f = cyc;
        idle(40);
        check("t1_start0", start_cyc[0], f + 1);
        check("t1_start1", start_cyc[1], f + 7);
        check("t1_start2", start_cyc[2], f + 13);
        check("t1_first_no_swap", swap_cyc, -1);
        step(1'b1); f = cyc;
        idle(3);
        check("t1_swap", swap_cyc, f + 1);
        idle(20);

        // Frame coincident with the last done
        step(1'b1); f = cyc;
        repeat (17) step(1'b0);
        step(1'b1); f2 = cyc;
        idle(2);
        check("t4_frame_at", f2, f + 18);
        check("t4_swap", swap_cyc, f2 + 1);
        check("t4_overrun", int'(overrun_count), 0);
        check("t4_restart", start_cyc[0], f2 + 1);
        idle(25);

        // Source 1 disabled
        enable_mask = 3'b101;
        dly = '{3, 3, 3};
        clear_log();
        step(1'b1); f = cyc;
        idle(20);
        check("t2_start0", start_cyc[0], f + 1);
        check("t2_start2", start_cyc[2], f + 5);
        check("t2_skip1", start_cyc[1], -1);

        // Overrun: source 2 outlives the frame period
        enable_mask = 3'b111;
        dly = '{5, 5, 40};
        step(1'b1); f = cyc;
        repeat (29) step(1'b0);
        step(1'b1);
        idle(2);
        check("t3_overrun", int'(overrun_count), 1);
        check("t3_no_swap", swap_cyc, f + 1);
        repeat (27) step(1'b0);
        step(1'b1);
        idle(2);
        check("t3_late_swap", swap_cyc, f + 61);
        idle(10);

        // Asynchronous reset while source 1 owns the bus
        dly = '{5, 5, 5};
        step(1'b1); f = cyc;
        repeat (9) step(1'b0);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("t5_drawing", int'(drawing), 0);
        check("t5_sel", int'(write_source_sel), 0);
        check("t5_overrun", int'(overrun_count), 0);
        clear_log();
        @(posedge clk);
        #1 resetN = 1'b1;
        idle(10);
        check("t5_quiet", int'(start_cyc[0] == -1 && start_cyc[1] == -1 && start_cyc[2] == -1), 1);
        step(1'b1); f = cyc;
        idle(3);
        check("t5_first_no_swap", swap_cyc, -1);
        check("t5_start0", start_cyc[0], f + 1);
        idle(20);

`ifdef DRAW_SEQ_TIMEOUT_EN
        // Source 1 never finishes; watchdog aborts it
        dly = '{5, 100000, 5};
        clear_log();
        step(1'b1);
        idle(70);
        check("t6_abort_latency", abort_cyc[1] - start_cyc[1], 51);
        check("t6_timeout_count", int'(timeout_count), 1);
        check("t6_next_start", start_cyc[2], abort_cyc[1] + 1);
        for (int i = 0; i < NS; i++) due[i] = -1;
        idle(10);
`else
        // Overrun counter saturates while a source hangs
        enable_mask = 3'b001;
        dly = '{2000, 5, 5};
        clear_log();
        step(1'b1);
        repeat (300) begin step(1'b0); step(1'b1); end
        step(1'b0);
        check("sat_overrun", int'(overrun_count), 255);
        @(posedge clk);
        #1 resetN = 1'b0;
        clear_log();
        @(posedge clk);
        #1 resetN = 1'b1;
        idle(3);
`endif

        // Random masks (changing every cycle), draw lengths, frame spacing and stray dones
        noise_en = 1'b1;
        rand_mask = 1'b1;
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < NS; i++) dly[i] = $urandom_range(1, 10);
            step(1'b1);
            idle($urandom_range(1, 45));
        end
        noise_en = 1'b0;
        rand_mask = 1'b0;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
